regfile: RTL and testbench
==========================

Name: regfile

Overview:
- 32 x 32-bit general-purpose register file for the MIPS CPU core.
- One synchronous write port and two independent combinational read ports.
- Read from the decode stage; written by the write-back stage.
- Register 0 is hardwired to zero, per the MIPS convention.

Parameters:
- RegAddrWidth, 5: register address width.
- RegDataWidth, 32: register data width.
- RegNum, 32: number of registers; must equal 2**RegAddrWidth.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- waddr  in  RegAddrWidth  write address.
- wdata  in  RegDataWidth  write data.
- we  in  1  write enable, active-high.
- re1  in  1  read port 1 enable, active-high.
- raddr_1  in  RegAddrWidth  read port 1 address.
- rdata_1  out  RegDataWidth  read port 1 data.
- re2  in  1  read port 2 enable, active-high.
- raddr_2  in  RegAddrWidth  read port 2 address.
- rdata_2  out  RegDataWidth  read port 2 data.

Behaviour:
- Storage:
  - Array of RegNum entries x RegDataWidth, named regs.
  - Declared as a reg array so benches can preload it hierarchically (e.g. $readmemb into <inst>.regs).
- Reset:
  - Synchronous, active-high.
  - On a rising clk edge with rst=1, all entries clear to 0 and any write that cycle is dropped.
  - While rst=1, rdata_1 and rdata_2 are 0 (combinational, independent of the clock).
- Write:
  - On a rising clk edge with rst=0, we=1 and waddr != 0: regs[waddr] <= wdata.
  - Writes to address 0 are discarded.
  - we=0: no change.
- Read ports (each port identical and independent, purely combinational, zero latency):
  - Priority 1: rst=1 -> 0.
  - Priority 2: reN=0 -> 0.
  - Priority 3: raddr_N=0 -> 0, even if regs[0] holds a preloaded non-zero value.
  - Priority 4: we=1 and waddr==raddr_N -> wdata (write-through bypass, same cycle).
  - Otherwise -> regs[raddr_N].
- Simultaneous events:
  - Both ports may read the same address.
  - Both ports may hit the bypass at the same time.
  - Reset overrides write, bypass and reads.
- No X propagation:
  - Unknown or disabled enables never drive stored data out.
  - Outputs default to 0.

Test Plan:
1. Preload regs[i]=i*3+1 via memory load; rst=0, re1=1; sweep raddr_1 over 0..31 -> rdata_1 = 0 at address 0, i*3+1 otherwise.
2. Sequential writes: one per clock, we=1, waddr=i, wdata=i for i=0..31; then re2=1 and sweep raddr_2 -> rdata_2 = i for i>=1, rdata_2 = 0 at address 0.
3. Bypass: we=1, waddr=7, wdata=32'hDEADBEEF with re1=1, raddr_1=7 before the clock edge -> rdata_1 = 32'hDEADBEEF immediately. After the edge with we=0 -> still 32'hDEADBEEF.
4. Enables: re1=0 and re2=0 with valid non-zero contents -> both outputs 0. Re-assert re1 only -> port 1 shows data, port 2 stays 0.
5. Reset: from populated contents, assert rst=1 for one clock edge -> outputs are 0 while rst=1. Deassert rst and sweep both ports with re=1 -> all 32 entries read 0.
6. Reset vs write collision: rst=1, we=1, waddr=5, wdata=5 across one edge -> after rst deasserts, regs[5] reads 0. Also, a write to address 0 with wdata=32'hFFFFFFFF -> reading address 0 returns 0.

Source files
------------

// File: rtl/regfile.sv
// 32 x 32-bit MIPS register file: one synchronous write port, two combinational
// read ports with same-cycle write-through bypass. Register 0 always reads zero.
module regfile #(
  parameter int RegAddrWidth = 5,
  parameter int RegDataWidth = 32,
  parameter int RegNum       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RegAddrWidth-1:0] waddr,
  input  logic [RegDataWidth-1:0] wdata,
  input  logic                    we,
  input  logic                    re1,
  input  logic [RegAddrWidth-1:0] raddr_1,
  output logic [RegDataWidth-1:0] rdata_1,
  input  logic                    re2,
  input  logic [RegAddrWidth-1:0] raddr_2,
  output logic [RegDataWidth-1:0] rdata_2
);

  reg [RegDataWidth-1:0] regs [0:RegNum-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RegNum; i++) begin
        regs[i] <= '0;
      end
    end else if (we == 1'b1 && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // Enables are compared against 1 so an unknown enable falls through to zero.
  always_comb begin
    rdata_1 = '0;
    if (rst == 1'b0 && re1 == 1'b1 && raddr_1 != '0) begin
      if (we == 1'b1 && waddr == raddr_1) begin
        rdata_1 = wdata;
      end else begin
        rdata_1 = regs[raddr_1];
      end
    end
  end

  always_comb begin
    rdata_2 = '0;
    if (rst == 1'b0 && re2 == 1'b1 && raddr_2 != '0) begin
      if (we == 1'b1 && waddr == raddr_2) begin
        rdata_2 = wdata;
      end else begin
        rdata_2 = regs[raddr_2];
      end
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus a randomized run
// compared against an array-based reference model of the register file.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        we;
  logic        re1;
  logic [4:0]  raddr_1;
  logic [31:0] rdata_1;
  logic        re2;
  logic [4:0]  raddr_2;
  logic [31:0] rdata_2;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];

  regfile dut (
    .clk(clk), .rst(rst), .waddr(waddr), .wdata(wdata), .we(we),
    .re1(re1), .raddr_1(raddr_1), .rdata_1(rdata_1),
    .re2(re2), .raddr_2(raddr_2), .rdata_2(rdata_2)
  );

  always #5 clk = ~clk;

  // What a read port should show right now, given the current inputs and model.
  function automatic logic [31:0] expected_read(input logic re, input logic [4:0] addr);
    if (rst) return 32'd0;
    if (!re) return 32'd0;
    if (addr == 5'd0) return 32'd0;
    if (we && waddr == addr) return wdata;
    return model[addr];
  endfunction

  // Advance one clock edge, applying the same edge to the model, then park on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (we && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; re1 = 1'b1; re2 = 1'b1;
    waddr = '0; wdata = '0; raddr_1 = 5'd3; raddr_2 = 5'd17;
    step();
    step();
    #1;
    checks++;
    if (rdata_1 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_rd1 got %h want %h", rdata_1, 32'd0);
    end
    checks++;
    if (rdata_2 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_rd2 got %h want %h", rdata_2, 32'd0);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_preload();
    for (int i = 0; i < 32; i++) begin
      dut.regs[i] = 32'(i * 3 + 1);
      model[i] = 32'(i * 3 + 1);
    end
    re1 = 1'b1; re2 = 1'b0; we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr_1 = 5'(i);
      #1;
      checks++;
      if (rdata_1 !== ((i == 0) ? 32'd0 : 32'(i * 3 + 1))) begin
        errors++;
        $display("[TB] FAIL preload_rd1 addr %0d got %h want %h", i, rdata_1,
                 (i == 0) ? 32'd0 : 32'(i * 3 + 1));
      end
    end
  endtask

  task automatic test_seq_write();
    re1 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i);
      step();
    end
    we = 1'b0; re2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      raddr_2 = 5'(i);
      #1;
      checks++;
      if (rdata_2 !== 32'(i)) begin
        errors++;
        $display("[TB] FAIL seq_write_rd2 addr %0d got %h want %h", i, rdata_2, 32'(i));
      end
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF;
    re1 = 1'b1; raddr_1 = 5'd7; re2 = 1'b1; raddr_2 = 5'd7;
    #1;
    checks++;
    if (rdata_1 !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL bypass_rd1 got %h want %h", rdata_1, 32'hDEADBEEF);
    end
    checks++;
    if (rdata_2 !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL bypass_rd2 got %h want %h", rdata_2, 32'hDEADBEEF);
    end
    step();
    we = 1'b0;
    #1;
    checks++;
    if (rdata_1 !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL bypass_stored got %h want %h", rdata_1, 32'hDEADBEEF);
    end
  endtask

  task automatic test_enables();
    we = 1'b0; re1 = 1'b0; re2 = 1'b0; raddr_1 = 5'd3; raddr_2 = 5'd9;
    #1;
    checks++;
    if (rdata_1 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL disabled_rd1 got %h want %h", rdata_1, 32'd0);
    end
    checks++;
    if (rdata_2 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL disabled_rd2 got %h want %h", rdata_2, 32'd0);
    end
    re1 = 1'b1;
    #1;
    checks++;
    if (rdata_1 !== 32'd3) begin
      errors++;
      $display("[TB] FAIL enabled_rd1 got %h want %h", rdata_1, 32'd3);
    end
    checks++;
    if (rdata_2 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL still_disabled_rd2 got %h want %h", rdata_2, 32'd0);
    end
    step();
  endtask

  task automatic test_reset_clear();
    rst = 1'b1; re1 = 1'b1; re2 = 1'b1; raddr_1 = 5'd4; raddr_2 = 5'd7;
    #1;
    checks++;
    if (rdata_1 !== 32'd0 || rdata_2 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rst_outputs got %h/%h want 0/0", rdata_1, rdata_2);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr_1 = 5'(i); raddr_2 = 5'(31 - i);
      #1;
      checks++;
      if (rdata_1 !== 32'd0 || rdata_2 !== 32'd0) begin
        errors++;
        $display("[TB] FAIL cleared addr %0d/%0d got %h/%h want 0/0", i, 31 - i, rdata_1, rdata_2);
      end
    end
  endtask

  task automatic test_reset_collision();
    we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
    step();
    rst = 1'b1; wdata = 32'd5;
    step();
    rst = 1'b0; we = 1'b0; re1 = 1'b1; raddr_1 = 5'd5;
    #1;
    checks++;
    if (rdata_1 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rst_write_collision got %h want %h", rdata_1, 32'd0);
    end
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr_1 = 5'd0;
    #1;
    checks++;
    if (rdata_1 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL zero_bypass got %h want %h", rdata_1, 32'd0);
    end
    step();
    we = 1'b0;
    #1;
    checks++;
    if (rdata_1 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL zero_write got %h want %h", rdata_1, 32'd0);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp1;
    logic [31:0] exp2;
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 31) == 0);
      we      = 1'($urandom_range(0, 1));
      waddr   = 5'($urandom_range(0, 31));
      wdata   = $urandom();
      re1     = ($urandom_range(0, 7) != 0);
      re2     = ($urandom_range(0, 7) != 0);
      raddr_1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr_2 = ($urandom_range(0, 3) == 0) ? raddr_1 : 5'($urandom_range(0, 31));
      #1;
      exp1 = expected_read(re1, raddr_1);
      exp2 = expected_read(re2, raddr_2);
      checks++;
      if (rdata_1 !== exp1) begin
        errors++;
        $display("[TB] FAIL random_rd1 iter %0d addr %0d got %h want %h", n, raddr_1, rdata_1, exp1);
      end
      checks++;
      if (rdata_2 !== exp2) begin
        errors++;
        $display("[TB] FAIL random_rd2 iter %0d addr %0d got %h want %h", n, raddr_2, rdata_2, exp2);
      end
      step();
    end
    rst = 1'b0; we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    rst = 1'b1; we = 1'b0; re1 = 1'b0; re2 = 1'b0;
    waddr = '0; wdata = '0; raddr_1 = '0; raddr_2 = '0;
    @(negedge clk);
    test_reset();
    test_preload();
    test_seq_write();
    test_bypass();
    test_enables();
    test_reset_clear();
    test_reset_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
